// File: rtl/cpu_pkg.sv
// Shared register-file definitions: widths, the zero register and the
// write-request record carried by the long-latency FIFO and the write port.
package cpu_pkg;

   localparam int REG_AW = 5;
   localparam int REG_DW = 32;

   localparam logic [REG_AW-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [REG_AW-1:0] number;
      logic [REG_DW-1:0] data;
   } wr_req_t;

endpackage

// File: rtl/wr_fifo.sv
// Small circular FIFO of register write requests from long-latency units.
// Full and empty come only from the registered count, so the producer's
// ready signal never depends combinationally on a same-cycle pop.
module wr_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic                   clk,
   input  logic                   clrn,
   input  logic                   push_i,
   input  wr_req_t                push_data_i,
   input  logic                   pop_i,
   output wr_req_t                head_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   empty_o
);

   localparam int PW = $clog2(DEPTH);

   wr_req_t       mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [PW:0]   count_q;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign full    = (count_q == (PW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];
   assign do_push = push_i && !full;
   assign do_pop  = pop_i && !empty_o;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset; an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/regfile_writer.sv
// Write-side front end of the register file. Pipeline writebacks win the
// single write port; buffered long-latency results fill idle slots in order.
// A busy scoreboard tracks registers whose long-latency result is pending.
module regfile_writer
   import cpu_pkg::*;
#(
   parameter int DW    = REG_DW,
   parameter int AW    = REG_AW,
   parameter int DEPTH = 4
)
(
   input  logic          clk,
   input  logic          clrn,
   input  logic          wb_en,
   input  logic [AW-1:0] wb_number,
   input  logic [DW-1:0] wb_data,
   input  logic          rsv_en,
   input  logic [AW-1:0] rsv_number,
   input  logic          lq_valid,
   input  logic [AW-1:0] lq_number,
   input  logic [DW-1:0] lq_data,
   output logic          lq_ready,
   input  logic [AW-1:0] r_number_a,
   input  logic [AW-1:0] r_number_b,
   output logic          busy_a,
   output logic          busy_b,
   output logic          w_en,
   output logic [AW-1:0] w_number,
   output logic [DW-1:0] w_data
);

   localparam int NREG = 2**AW;

   wr_req_t               fifo_in;
   wr_req_t               fifo_head;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                  fifo_empty;
   logic                  fifo_pop;
   logic                  wb_take;

   logic                  w_en_q,      w_en_d;
   logic [AW-1:0]         w_number_q,  w_number_d;
   logic [DW-1:0]         w_data_q,    w_data_d;
   logic                  from_fifo_q, from_fifo_d;
   logic [NREG-1:0]       busy_q,      busy_d;

   assign fifo_in.number = lq_number;
   assign fifo_in.data   = lq_data;
   assign lq_ready       = (fifo_count != ($clog2(DEPTH)+1)'(DEPTH));
   assign wb_take        = wb_en && (wb_number != REG_ZERO);
   assign fifo_pop       = !wb_take && !fifo_empty;

   wr_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .clrn        (clrn),
      .push_i      (lq_valid && lq_ready),
      .push_data_i (fifo_in),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .count_o     (fifo_count),
      .empty_o     (fifo_empty)
   );

   // Choose the write-port source: pipeline first, then the FIFO head, else idle with address/data held.
   always_comb begin
      w_en_d      = 1'b0;
      w_number_d  = w_number_q;
      w_data_d    = w_data_q;
      from_fifo_d = 1'b0;
      if (wb_take) begin
         w_en_d     = 1'b1;
         w_number_d = wb_number;
         w_data_d   = wb_data;
      end else if (!fifo_empty) begin
         w_en_d      = 1'b1;
         w_number_d  = fifo_head.number;
         w_data_d    = fifo_head.data;
         from_fifo_d = 1'b1;
      end
   end

   // Clear on the edge the register file stores a FIFO-sourced write; a same-edge reservation wins.
   always_comb begin
      busy_d = busy_q;
      if (w_en_q && from_fifo_q) busy_d[w_number_q] = 1'b0;
      if (rsv_en && (rsv_number != REG_ZERO)) busy_d[rsv_number] = 1'b1;
      busy_d[0] = 1'b0;
   end

   // Registered write port and scoreboard state.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         w_en_q      <= 1'b0;
         w_number_q  <= '0;
         w_data_q    <= '0;
         from_fifo_q <= 1'b0;
         busy_q      <= '0;
      end else begin
         w_en_q      <= w_en_d;
         w_number_q  <= w_number_d;
         w_data_q    <= w_data_d;
         from_fifo_q <= from_fifo_d;
         busy_q      <= busy_d;
      end
   end

   assign busy_a   = busy_q[r_number_a];
   assign busy_b   = busy_q[r_number_b];
   assign w_en     = w_en_q;
   assign w_number = w_number_q;
   assign w_data   = w_data_q;

endmodule

// File: tb/tb_regfile_writer.sv
// Directed bench for regfile_writer: reset, pipeline latency, long-latency
// round trip, priority/starvation, backpressure and same-edge set/clear.
module tb_regfile_writer;

   logic        clk;
   logic        clrn;
   logic        wb_en;
   logic [4:0]  wb_number;
   logic [31:0] wb_data;
   logic        rsv_en;
   logic [4:0]  rsv_number;
   logic        lq_valid;
   logic [4:0]  lq_number;
   logic [31:0] lq_data;
   logic        lq_ready;
   logic [4:0]  r_number_a;
   logic [4:0]  r_number_b;
   logic        busy_a;
   logic        busy_b;
   logic        w_en;
   logic [4:0]  w_number;
   logic [31:0] w_data;

   int checks;
   int errors;

   regfile_writer #(.DW(32), .AW(5), .DEPTH(4)) dut (
      .clk        (clk),
      .clrn       (clrn),
      .wb_en      (wb_en),
      .wb_number  (wb_number),
      .wb_data    (wb_data),
      .rsv_en     (rsv_en),
      .rsv_number (rsv_number),
      .lq_valid   (lq_valid),
      .lq_number  (lq_number),
      .lq_data    (lq_data),
      .lq_ready   (lq_ready),
      .r_number_a (r_number_a),
      .r_number_b (r_number_b),
      .busy_a     (busy_a),
      .busy_b     (busy_b),
      .w_en       (w_en),
      .w_number   (w_number),
      .w_data     (w_data)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one cycle; inputs driven and outputs sampled 2 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      clrn = 1'b0; wb_en = 1'b0; wb_number = '0; wb_data = '0;
      rsv_en = 1'b0; rsv_number = '0; lq_valid = 1'b0; lq_number = '0; lq_data = '0;
      r_number_a = 5'd5; r_number_b = 5'd0;
      step(); step();
      checks++;
      if (w_en !== 1'b0 || w_number !== 5'd0 || w_data !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got en=%b num=%0d data=%h, expected 0/0/0", w_en, w_number, w_data);
      end
      checks++;
      if (lq_ready !== 1'b1 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_status: got ready=%b busy_a=%b busy_b=%b, expected 1/0/0", lq_ready, busy_a, busy_b);
      end
      clrn = 1'b1;
      step();
      // Build a mid-stream state: r5,r6,r8 reserved, three entries queued behind a pipeline stream.
      rsv_en = 1'b1; rsv_number = 5'd5; step();
      rsv_number = 5'd6; step();
      rsv_number = 5'd8; wb_en = 1'b1; wb_number = 5'd20; wb_data = 32'h20; step();
      rsv_en = 1'b0;
      lq_valid = 1'b1; lq_number = 5'd5; lq_data = 32'h55; step();
      lq_number = 5'd6; lq_data = 32'h66; step();
      lq_number = 5'd8; lq_data = 32'h88; step();
      lq_valid = 1'b0;
      checks++;
      if (busy_a !== 1'b1) begin
         errors++;
         $display("[TB] FAIL prereset_busy5: got %b, expected 1", busy_a);
      end
      clrn = 1'b0; wb_en = 1'b0;
      #1;
      checks++;
      if (w_en !== 1'b0 || lq_ready !== 1'b1 || busy_a !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_reset: got en=%b ready=%b busy_a=%b, expected 0/1/0", w_en, lq_ready, busy_a);
      end
      step();
      clrn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (w_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_discard_%0d: got w_en=%b num=%0d, expected 0", i, w_en, w_number);
         end
      end
   endtask

   task automatic test_pipeline();
      wb_en = 1'b1; wb_number = 5'd7; wb_data = 32'hDEADBEEF;
      step();
      wb_en = 1'b0;
      checks++;
      if (w_en !== 1'b1 || w_number !== 5'd7 || w_data !== 32'hDEADBEEF) begin
         errors++;
         $display("[TB] FAIL pipe_write: got en=%b num=%0d data=%h, expected 1/7/deadbeef", w_en, w_number, w_data);
      end
      step();
      checks++;
      if (w_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL pipe_single_cycle: got w_en=%b, expected 0", w_en);
      end
      wb_en = 1'b1; wb_number = 5'd0; wb_data = 32'h55;
      step();
      wb_en = 1'b0;
      checks++;
      if (w_en !== 1'b0 || w_number !== 5'd7 || w_data !== 32'hDEADBEEF) begin
         errors++;
         $display("[TB] FAIL pipe_r0_ignored: got en=%b num=%0d data=%h, expected 0/7/deadbeef", w_en, w_number, w_data);
      end
   endtask

   task automatic test_round_trip();
      r_number_a = 5'd9;
      rsv_en = 1'b1; rsv_number = 5'd9;
      step();
      rsv_en = 1'b0;
      checks++;
      if (busy_a !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rt_busy_set: got %b, expected 1", busy_a);
      end
      repeat (4) step();
      checks++;
      if (lq_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rt_ready: got %b, expected 1", lq_ready);
      end
      lq_valid = 1'b1; lq_number = 5'd9; lq_data = 32'h1234;
      step();
      lq_valid = 1'b0;
      checks++;
      if (w_en !== 1'b0 || busy_a !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rt_t6: got en=%b busy_a=%b, expected 0/1", w_en, busy_a);
      end
      step();
      checks++;
      if (w_en !== 1'b1 || w_number !== 5'd9 || w_data !== 32'h1234 || busy_a !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rt_commit: got en=%b num=%0d data=%h busy_a=%b, expected 1/9/1234/1", w_en, w_number, w_data, busy_a);
      end
      step();
      checks++;
      if (busy_a !== 1'b0 || w_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rt_busy_clear: got busy_a=%b en=%b, expected 0/0", busy_a, w_en);
      end
   endtask

   task automatic test_priority_starvation();
      r_number_b = 5'd3;
      rsv_en = 1'b1; rsv_number = 5'd3;
      step();
      rsv_en = 1'b0;
      lq_valid = 1'b1; lq_number = 5'd3; lq_data = 32'hA;
      step();
      lq_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wb_en = 1'b1; wb_number = 5'(10 + i); wb_data = 32'(100 + i);
         step();
         checks++;
         if (w_en !== 1'b1 || w_number !== 5'(10 + i) || w_data !== 32'(100 + i) || busy_b !== 1'b1) begin
            errors++;
            $display("[TB] FAIL prio_wb_%0d: got en=%b num=%0d data=%0d busy=%b, expected 1/%0d/%0d/1",
                     i, w_en, w_number, w_data, busy_b, 10 + i, 100 + i);
         end
      end
      wb_en = 1'b0;
      step();
      checks++;
      if (w_en !== 1'b1 || w_number !== 5'd3 || w_data !== 32'hA || busy_b !== 1'b1) begin
         errors++;
         $display("[TB] FAIL prio_fifo_commit: got en=%b num=%0d data=%h busy=%b, expected 1/3/a/1", w_en, w_number, w_data, busy_b);
      end
      step();
      checks++;
      if (busy_b !== 1'b0 || w_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL prio_busy_clear: got busy=%b en=%b, expected 0/0", busy_b, w_en);
      end
   endtask

   task automatic test_full_backpressure();
      wb_en = 1'b1; wb_number = 5'd30; wb_data = 32'h30;
      rsv_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rsv_number = 5'(21 + i);
         step();
      end
      rsv_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (lq_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_ready_push%0d: got %b, expected 1", i, lq_ready);
         end
         lq_valid = 1'b1; lq_number = 5'(21 + i); lq_data = 32'(i + 1);
         step();
      end
      lq_number = 5'd21; lq_data = 32'hBAD;
      checks++;
      if (lq_ready !== 1'b0 || w_en !== 1'b1 || w_number !== 5'd30) begin
         errors++;
         $display("[TB] FAIL bp_full: got ready=%b en=%b num=%0d, expected 0/1/30", lq_ready, w_en, w_number);
      end
      wb_en = 1'b0;
      step();
      lq_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (w_en !== 1'b1 || w_number !== 5'(21 + i) || w_data !== 32'(i + 1)) begin
            errors++;
            $display("[TB] FAIL bp_pop_%0d: got en=%b num=%0d data=%h, expected 1/%0d/%0d", i, w_en, w_number, w_data, 21 + i, i + 1);
         end
         if (i == 0) begin
            checks++;
            if (lq_ready !== 1'b1) begin
               errors++;
               $display("[TB] FAIL bp_ready_after_pop: got %b, expected 1", lq_ready);
            end
         end
         step();
      end
      checks++;
      if (w_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_drained: got en=%b num=%0d data=%h, expected en=0", w_en, w_number, w_data);
      end
   endtask

   task automatic test_same_edge();
      r_number_a = 5'd4;
      rsv_en = 1'b1; rsv_number = 5'd4;
      step();
      rsv_en = 1'b0;
      lq_valid = 1'b1; lq_number = 5'd4; lq_data = 32'h44;
      step();
      lq_valid = 1'b0;
      step();
      checks++;
      if (w_en !== 1'b1 || w_number !== 5'd4 || busy_a !== 1'b1) begin
         errors++;
         $display("[TB] FAIL same_commit: got en=%b num=%0d busy=%b, expected 1/4/1", w_en, w_number, busy_a);
      end
      rsv_en = 1'b1; rsv_number = 5'd4;
      step();
      rsv_en = 1'b0;
      checks++;
      if (busy_a !== 1'b1) begin
         errors++;
         $display("[TB] FAIL same_edge_set_wins: got %b, expected 1", busy_a);
      end
      step();
      checks++;
      if (busy_a !== 1'b1) begin
         errors++;
         $display("[TB] FAIL same_edge_hold: got %b, expected 1", busy_a);
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_pipeline();
      test_round_trip();
      test_priority_starvation();
      test_full_backpressure();
      test_same_edge();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_writer.md
Name: regfile_writer

Overview:
- Write-side front end for the 32-entry CPU register file; owns and drives its single write port (w_number, w_data, w_en).
- Merges two result sources: the in-order pipeline writeback, which has fixed priority, and long-latency completions (MDU/load unit), which are buffered in a small FIFO.
- Keeps a per-register busy scoreboard so decode can stall on operands whose long-latency result is still pending.

Parameters:
- DW, 32, data width.
- AW, 5, register-number width (2^AW registers; register 0 hardwired zero).
- DEPTH, 4, long-latency FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- clrn  in  1  asynchronous active-low reset.
- wb_en  in  1  pipeline writeback valid.
- wb_number  in  AW  pipeline destination register.
- wb_data  in  DW  pipeline result.
- rsv_en  in  1  long-latency op issued; reserve its destination.
- rsv_number  in  AW  register to reserve.
- lq_valid  in  1  long-latency result offered.
- lq_number  in  AW  long-latency destination.
- lq_data  in  DW  long-latency result.
- lq_ready  out  1  FIFO can accept.
- r_number_a  in  AW  decode operand A register.
- r_number_b  in  AW  decode operand B register.
- busy_a  out  1  operand A pending (combinational from scoreboard).
- busy_b  out  1  operand B pending.
- w_en  out  1  register-file write enable (registered).
- w_number  out  AW  register-file write address (registered).
- w_data  out  DW  register-file write data (registered).

Behaviour:
- Reset (clrn=0, asynchronous):
  - w_en=0, w_number=0, w_data=0.
  - FIFO empty; lq_ready=1.
  - All busy bits 0; busy_a=busy_b=0.
  - Any operation in flight is discarded.
- FIFO:
  - Push when lq_valid & lq_ready.
  - lq_ready = (count != DEPTH), registered-state only; no combinational path from lq_valid or the pop.
  - Full with a pop in the same cycle: lq_ready stays 0 that cycle.
  - Push into an empty FIFO: the entry becomes head on the next cycle.
  - Pointers wrap modulo DEPTH; count is AW-independent, $clog2(DEPTH)+1 bits.
- Write-port select, evaluated every rising edge:
  - If wb_en & wb_number!=0: load {1, wb_number, wb_data}.
  - Else if FIFO non-empty: pop head and load {1, head}.
  - Else: w_en<=0 (w_number/w_data hold).
  - wb_en with wb_number=0 is ignored and does not block the FIFO.
- Latency:
  - Pipeline: wb_en at cycle t -> w_en=1 during t+1.
  - Long-latency, best case (empty FIFO, no wb_en at t+1): push at t -> w_en during t+2.
  - Each cycle wb_en is active delays queued entries by one cycle.
  - A sustained pipeline stream starves the FIFO; producers rely on lq_ready backpressure.
- Scoreboard (2^AW bits, bit 0 constant 0):
  - Set: rsv_en & rsv_number!=0 sets busy[rsv_number].
  - Clear: the edge at which w_en=1 and the committed entry came from the FIFO clears busy[w_number]. This is the same edge the register file stores the data, so the cycle after busy drops, the read port returns the new value.
  - Set and clear of the same register on the same edge: set wins.
  - Pipeline (wb) writes never touch busy.
  - busy_a = busy[r_number_a]; busy_b = busy[r_number_b]; register 0 always reads not-busy.
- Protocol rules (bench asserts, RTL behaviour undefined):
  - rsv_en to an already-busy register.
  - lq push to a non-busy register.
  - wb_en to a busy register (WAW hazard; decode must stall).
- Ordering: FIFO entries commit in push order.

Decomposition:
- Shared cpu_pkg: REG_AW=5, REG_DW=32, REG_ZERO constant, and a typedef wr_req_t {number, data} used by the FIFO and the write-port register.
- One sub-module: wr_fifo (DEPTH x wr_req_t, push/pop/count, full/empty).
- Scoreboard and write-port select stay in regfile_writer.

Test Plan:
- Reset: assert clrn=0 mid-stream with 3 entries queued and busy[5]=1 -> next cycle w_en=0, lq_ready=1, busy_a=0 for r_number_a=5; queued entries never written.
- Pipeline latency: wb_en=1, wb_number=7, wb_data=0xDEADBEEF at cycle 10 -> w_en=1, w_number=7, w_data=0xDEADBEEF at cycle 11 only; wb_number=0 -> w_en stays 0.
- Long-latency round trip: rsv r9 at t0 -> busy_a=1 for r_number_a=9 from t0+1; push {9, 0x1234} at t5 -> w_en with 9/0x1234 at t7; busy_a=0 from t8.
- Priority and starvation: FIFO holds {3, 0xA}; wb_en active for 4 consecutive cycles -> 4 pipeline writes first, then {3, 0xA} commits in the following cycle; busy[3] stays 1 until that commit.
- Full/backpressure: with wb_en held high, push 4 entries -> lq_ready=0; drop wb_en -> pops in order 1,2,3,4; lq_ready=1 one cycle after the first pop.
- Same-edge set and clear: commit of r4 from the FIFO and rsv_en r4 on the same edge -> busy[4]=1 afterwards.
